vmul_pipe: RTL

Pipelined, parametrised vector multiply unit for the vector execute path. It generalises the combinational 8-bit lane multiplier to three element widths (8/16/32) and four RISC-V multiply flavours (low, high signed, high unsigned, high signed×unsigned). It registers results through a configurable pipeline with a valid/ready handshake and backpressure. It sits between operand read and vector writeback, and zero-fills register-group slots beyond the active LMUL.

---
 rtl/vmul_pkg.sv | 60 ++++++
 rtl/vmul_lane32.sv | 102 ++++++++++
 rtl/vmul_pipe.sv | 96 +++++++++
 3 files changed

// File: rtl/vmul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vmul_pkg
// Purpose  : Shared types, encodings and helpers for the vector multiply unit.
//            Holds the element-width and multiply-flavour enums, the vlmul
//            encodings, the vlmul legality check and the active-width mask
//            generator used to zero register-group slots beyond LMUL.
// Revision : 1.0 - initial release
// ============================================================================
package vmul_pkg;

  // Element width selector (vsew field)
  typedef enum logic [1:0] {
    SEW_8    = 2'b00,
    SEW_16   = 2'b01,
    SEW_32   = 2'b10,
    SEW_RSVD = 2'b11
  } sew_e;

  // Multiply flavour (mul_op field)
  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHU  = 2'b10,
    OP_MULHSU = 2'b11
  } mul_op_e;

  // Legal register-group encodings (vlmul field)
  localparam logic [2:0] c_lmul_1 = 3'b000;
  localparam logic [2:0] c_lmul_2 = 3'b001;
  localparam logic [2:0] c_lmul_4 = 3'b010;
  localparam logic [2:0] c_lmul_8 = 3'b011;

  // Upper bound on VLEN supported by the mask helper; callers truncate the
  // returned mask to their own VLEN.
  localparam int unsigned c_mask_max_w = 4096;

  function automatic logic vlmul_legal(input logic [2:0] vlmul);
    return (vlmul == c_lmul_1) || (vlmul == c_lmul_2) ||
           (vlmul == c_lmul_4) || (vlmul == c_lmul_8);
  endfunction

  // Ones for every bit below the active width (reg_w << vlmul), built a
  // 32-bit word at a time since REG_W is always a multiple of 32.
  function automatic logic [c_mask_max_w-1:0] active_mask(input logic [2:0]  vlmul,
                                                          input int unsigned reg_w);
    logic [c_mask_max_w-1:0] m;
    int unsigned             act;
    m   = '0;
    act = reg_w << vlmul;
    for (int unsigned w = 0; w < c_mask_max_w / 32; w++) begin
      if (w * 32 < act) begin
        m[w*32 +: 32] = '1;
      end
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vmul_lane32.sv
`default_nettype none
// ============================================================================
// Module   : vmul_lane32
// Purpose  : One 32-bit multiply lane. Computes 4x8, 2x16 or 1x32 element
//            products selected by i_sew, returning the low or high half of
//            each 2*SEW product according to i_op. Purely combinational.
// Ports    : i_a   [31:0] multiplicand lane slice (vs2)
//            i_b   [31:0] multiplier lane slice (vs1)
//            i_sew        element width
//            i_op         multiply flavour
//            o_res [31:0] lane result (0 for reserved SEW)
// Revision : 1.0 - initial release
// ============================================================================
module vmul_lane32
  import vmul_pkg::*;
(
  input  logic    [31:0] i_a,
  input  logic    [31:0] i_b,
  input  sew_e           i_sew,
  input  mul_op_e        i_op,
  output logic    [31:0] o_res
);

  // Operands are extended to 2*SEW bits (sign- or zero-extended per flavour)
  // and multiplied modulo 2^(2*SEW); those bits equal the exact product for
  // all of s*s, u*u and s*u.
  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b,
                                       input logic sa, input logic sb);
    logic [15:0] ax;
    logic [15:0] bx;
    ax = {{8{sa & a[7]}}, a};
    bx = {{8{sb & b[7]}}, b};
    return ax * bx;
  endfunction

  function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b,
                                        input logic sa, input logic sb);
    logic [31:0] ax;
    logic [31:0] bx;
    ax = {{16{sa & a[15]}}, a};
    bx = {{16{sb & b[15]}}, b};
    return ax * bx;
  endfunction

  function automatic logic [63:0] mul32(input logic [31:0] a, input logic [31:0] b,
                                        input logic sa, input logic sb);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {{32{sa & a[31]}}, a};
    bx = {{32{sb & b[31]}}, b};
    return ax * bx;
  endfunction

  logic        w_sa;
  logic        w_sb;
  logic        w_hi;
  logic [15:0] w_p8  [4];
  logic [31:0] w_p16 [2];
  logic [63:0] w_p32;
  logic [31:0] w_res;

  // MUL returns the low half, which is signedness-independent.
  assign w_sa = (i_op == OP_MULH) || (i_op == OP_MULHSU);
  assign w_sb = (i_op == OP_MULH);
  assign w_hi = (i_op != OP_MUL);

  for (genvar k = 0; k < 4; k++) begin : g_e8
    assign w_p8[k] = mul8(i_a[8*k +: 8], i_b[8*k +: 8], w_sa, w_sb);
  end

  for (genvar k = 0; k < 2; k++) begin : g_e16
    assign w_p16[k] = mul16(i_a[16*k +: 16], i_b[16*k +: 16], w_sa, w_sb);
  end

  assign w_p32 = mul32(i_a, i_b, w_sa, w_sb);

  always_comb begin
    w_res = '0;
    case (i_sew)
      SEW_8: begin
        for (int k = 0; k < 4; k++) begin
          w_res[8*k +: 8] = w_hi ? w_p8[k][15:8] : w_p8[k][7:0];
        end
      end
      SEW_16: begin
        for (int k = 0; k < 2; k++) begin
          w_res[16*k +: 16] = w_hi ? w_p16[k][31:16] : w_p16[k][15:0];
        end
      end
      SEW_32: begin
        w_res = w_hi ? w_p32[63:32] : w_p32[31:0];
      end
      default: begin
        w_res = '0;
      end
    endcase
  end

  assign o_res = w_res;

endmodule
`default_nettype wire

// File: rtl/vmul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : vmul_pipe
// Purpose  : Pipelined vector multiply unit (SEW 8/16/32; MUL, MULH, MULHU,
//            MULHSU). Combinational multiply at the input, followed by
//            STAGES register stages under a single global enable with
//            valid/ready handshake. Result bits above REG_W<<vlmul are zeroed;
//            illegal vlmul/vsew requests produce zero data with cfg_err set.
// Ports    : clk, rst_n (async, active-low)
//            in_valid / in_ready          request handshake
//            op0_value, op1_value [VLEN]  vs2, vs1 operands
//            vlmul [3], vsew [2], mul_op [2]  request configuration
//            out_valid / out_ready        result handshake
//            mul_out [VLEN], cfg_err      result and config-error flag
// Revision : 1.0 - initial release
// ============================================================================
module vmul_pipe
  import vmul_pkg::*;
#(
  parameter int VLEN   = 256,
  parameter int REG_W  = 32,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [VLEN-1:0] op0_value,
  input  logic [VLEN-1:0] op1_value,
  input  logic [2:0]      vlmul,
  input  logic [1:0]      vsew,
  input  logic [1:0]      mul_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VLEN-1:0] mul_out,
  output logic            cfg_err
);

  localparam int c_lanes = VLEN / 32;

  logic [VLEN-1:0] w_raw;
  logic [VLEN-1:0] w_mask;
  logic [VLEN-1:0] w_res;
  logic            w_legal;
  logic            w_en;

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_err;
  logic [VLEN-1:0]   r_data [STAGES];

  for (genvar l = 0; l < c_lanes; l++) begin : g_lane
    vmul_lane32 u_lane (
      .i_a   (op0_value[32*l +: 32]),
      .i_b   (op1_value[32*l +: 32]),
      .i_sew (sew_e'(vsew)),
      .i_op  (mul_op_e'(mul_op)),
      .o_res (w_raw[32*l +: 32])
    );
  end

  assign w_legal = vlmul_legal(vlmul) && (sew_e'(vsew) != SEW_RSVD);
  assign w_mask  = VLEN'(active_mask(vlmul, REG_W));
  assign w_res   = w_legal ? (w_raw & w_mask) : '0;

  // One enable for the whole pipe: everything moves unless the tail holds a
  // result that downstream refuses. Bubbles are kept, not collapsed.
  assign w_en     = !r_valid[STAGES-1] || out_ready;
  assign in_ready = w_en;

  // Data of an empty slot is forced to zero so the output bus never shows
  // operand-dependent garbage while out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_err   <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_data[s] <= '0;
      end
    end else if (w_en) begin
      r_valid[0] <= in_valid;
      r_err[0]   <= in_valid && !w_legal;
      r_data[0]  <= in_valid ? w_res : '0;
      for (int s = 1; s < STAGES; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_err[s]   <= r_err[s-1];
        r_data[s]  <= r_data[s-1];
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign cfg_err   = r_err[STAGES-1];
  assign mul_out   = r_data[STAGES-1];

endmodule
`default_nettype wire
